gpu_seq_controller: RTL and testbench
=====================================

Name: gpu_seq_controller

Overview:
- Parametrised top-level sequencer for the 2D GPU.
- Handles configuration, then fetches instructions from the command FIFO.
- Each instruction carries an engine mask; the block dispatches the selected engines (BLA, FILL, ALPHA, ...) one at a time in ascending index order.
- Adds watchdog timeout, sticky error and an instruction counter over the first-generation controller.

Parameters:
- NUM_ENG, 4, number of drawing engines (index 0 = BLA, 1 = FILL, 2 = ALPHA, 3 = spare).
- TO_W, 16, width of the watchdog counter.
- TIMEOUT_CYC, 50000, max cycles an engine may stay enabled without done; 0 disables the watchdog.
- CNT_W, 16, width of the completed-instruction counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- config_in  in  1  request to start a configuration pass
- config_done  in  1  configuration unit finished
- fifo_empty  in  1  command FIFO empty; FIFO is first-word-fall-through, so data is valid whenever this is 0
- inst_mask  in  NUM_ENG  engine mask of the FIFO head instruction
- inst_last  in  1  head instruction is the final one of the frame
- eng_done  in  NUM_ENG  per-engine done pulses
- clear_err  in  1  leave ERROR state
- read_en  out  1  FIFO pop strobe
- config_en  out  1  configuration unit enable
- eng_en  out  NUM_ENG  engine enables, one-hot or zero
- busy  out  1  sequencer active
- error  out  1  watchdog fired (sticky)
- inst_count  out  CNT_W  instructions completed since reset

Behaviour:
- Reset: clk domain; n_rst is asynchronous, active-low.
  - Asserting n_rst at any time, including mid-dispatch, forces IDLE immediately.
  - Clears the latched mask, the watchdog and inst_count.
  - All outputs are 0 in reset.
- States: IDLE, CONFIG, CFG_GAP, FETCH, RUN, GAP, ERROR. Registered state; outputs decoded combinationally from state and registers.
- IDLE:
  - All enables are 0.
  - config_in=1 → CONFIG next cycle.
- CONFIG:
  - config_en=1.
  - config_done=1 → CFG_GAP.
- CFG_GAP: one cycle, all enables 0 → FETCH.
- FETCH:
  - While fifo_empty=1: stay, read_en=0.
  - When fifo_empty=0: read_en=1 for exactly that cycle; inst_mask→pend_mask and inst_last→last_r are latched at the same edge.
  - If inst_mask=0: no engine runs; inst_count increments at that edge; next state is IDLE if inst_last, else FETCH.
  - Otherwise: cur = index of the lowest set bit → RUN.
- RUN:
  - eng_en[cur]=1 and all other bits 0; the watchdog counts cycles in RUN.
  - eng_done[cur]=1 → GAP, clears pend_mask[cur] and the watchdog.
  - eng_done on any other index is ignored.
  - If the watchdog reaches TIMEOUT_CYC-1 without done (and TIMEOUT_CYC≠0) → ERROR.
  - If done and timeout occur in the same cycle, done wins.
- GAP:
  - One cycle, all enables 0.
  - If pend_mask≠0: cur = next lowest set bit → RUN.
  - Else: inst_count increments; next state is IDLE if last_r, else FETCH.
- ERROR:
  - error=1, all enables 0; the instruction is abandoned and not counted.
  - clear_err=1 → IDLE; error returns to 0 in IDLE.
- busy=1 in CONFIG, CFG_GAP, FETCH, RUN and GAP; 0 in IDLE and ERROR.
- Latency:
  - Pop to first eng_en is 1 cycle.
  - Engine done to next engine eng_en is 2 cycles (through GAP).
  - Final done to next read_en is 2 cycles at minimum.
- inst_count wraps modulo 2^CNT_W without saturating.
- Inputs config_in, config_done and eng_done are ignored in states where they are not listed.

Test Plan:
- Reset, config_in pulse, config_done after 5 cycles → config_en high for exactly 5 cycles, one idle cycle, then FETCH with read_en=0 while fifo_empty=1.
- FIFO holds mask 0011 (last=0) then 0100 (last=1), each engine's done arrives 3 cycles after its enable → eng_en sequence 0001, 0010, 0100 with one zero GAP cycle between each; two read_en pulses; inst_count=2; returns to IDLE with busy=0.
- Mask 0000, last=0, followed by mask 0001, last=1 → first instruction is popped and counted with no eng_en; second runs engine 0; inst_count=2.
- TIMEOUT_CYC=8, engine 1 never signals done → eng_en=0010 for 8 cycles, then error=1 and eng_en=0; clear_err returns to IDLE; inst_count unchanged.
- eng_done=0100 asserted while engine 0 is running → ignored, eng_en stays 0001. A later eng_done=0001 coinciding with the watchdog limit → GAP, no error.
- n_rst asserted mid-RUN → all outputs 0 asynchronously; after release the block sits in IDLE with inst_count=0.

Source files
------------

// File: rtl/gpu_seq_controller.sv
// 2D GPU top-level sequencer: configuration pass, then dispatches engines from a
// FWFT command FIFO in ascending engine-index order, with a watchdog and an instruction counter.
module gpu_seq_controller #(
    parameter int NUM_ENG     = 4,
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               config_in,
    input  logic               config_done,
    input  logic               fifo_empty,
    input  logic [NUM_ENG-1:0] inst_mask,
    input  logic               inst_last,
    input  logic [NUM_ENG-1:0] eng_done,
    input  logic               clear_err,
    output logic               read_en,
    output logic               config_en,
    output logic [NUM_ENG-1:0] eng_en,
    output logic               busy,
    output logic               error,
    output logic [CNT_W-1:0]   inst_count
);

    localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 1);
    localparam bit WD_ON = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_CFG_GAP,
        S_FETCH,
        S_RUN,
        S_GAP,
        S_ERROR
    } state_t;

    state_t             state;
    logic [NUM_ENG-1:0] pend_mask;
    logic               last_r;
    logic [IDX_W-1:0]   cur;
    logic [TO_W-1:0]    wd;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_ENG-1:0] m);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (m[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            pend_mask  <= '0;
            last_r     <= 1'b0;
            cur        <= '0;
            wd         <= '0;
            inst_count <= '0;
        end else begin
            case (state)
                S_IDLE:    if (config_in) state <= S_CONFIG;
                S_CONFIG:  if (config_done) state <= S_CFG_GAP;
                S_CFG_GAP: state <= S_FETCH;
                S_FETCH: begin
                    if (!fifo_empty) begin
                        pend_mask <= inst_mask;
                        last_r    <= inst_last;
                        wd        <= '0;
                        if (inst_mask == '0) begin
                            inst_count <= inst_count + CNT_W'(1);
                            state      <= inst_last ? S_IDLE : S_FETCH;
                        end else begin
                            cur   <= lowest(inst_mask);
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (eng_done[cur]) begin
                        pend_mask[cur] <= 1'b0;
                        wd             <= '0;
                        state          <= S_GAP;
                    end else if (WD_ON && wd == TO_LIM) begin
                        wd    <= '0;
                        state <= S_ERROR;
                    end else begin
                        wd <= wd + TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (pend_mask != '0) begin
                        cur   <= lowest(pend_mask);
                        state <= S_RUN;
                    end else begin
                        inst_count <= inst_count + CNT_W'(1);
                        state      <= last_r ? S_IDLE : S_FETCH;
                    end
                end
                S_ERROR:   if (clear_err) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        eng_en = '0;
        if (state == S_RUN) eng_en[cur] = 1'b1;
        read_en   = (state == S_FETCH) && !fifo_empty;
        config_en = (state == S_CONFIG);
        error     = (state == S_ERROR);
        busy      = (state == S_CONFIG) || (state == S_CFG_GAP) || (state == S_FETCH) ||
                    (state == S_RUN) || (state == S_GAP);
    end

endmodule

// File: tb/tb_gpu_seq_controller.sv
// Bench for gpu_seq_controller: vector table, directed corner sequences, and
// randomized frames checked against a transaction-level queue model.
module tb_gpu_seq_controller;

    localparam int NE = 4;
    localparam int CW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic config_in = 1'b0, config_done = 1'b0, fifo_empty = 1'b1, inst_last = 1'b0, clear_err = 1'b0;
    logic [NE-1:0] inst_mask = '0, eng_done = '0;
    logic read_en, config_en, busy, error;
    logic [NE-1:0] eng_en;
    logic [CW-1:0] inst_count;

    int n_pass = 0;
    int n_tot  = 0;
    int mc     = 0;

    typedef struct {
        logic ci, cd, fe;
        logic [3:0] m;
        logic l;
        logic [3:0] d;
        logic clr;
        logic [15:0] e;
    } vec_t;
    vec_t vq[$];

    logic [3:0] fq_m[$];
    logic       fq_l[$];
    int         exp_eng[$];

    gpu_seq_controller #(.NUM_ENG(NE), .TO_W(16), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .n_rst(n_rst), .config_in(config_in), .config_done(config_done),
        .fifo_empty(fifo_empty), .inst_mask(inst_mask), .inst_last(inst_last),
        .eng_done(eng_done), .clear_err(clear_err), .read_en(read_en), .config_en(config_en),
        .eng_en(eng_en), .busy(busy), .error(error), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // {read_en, config_en, eng_en, busy, error, inst_count}
    function automatic logic [15:0] ev(input logic rd, cfg, input logic [3:0] en,
                                       input logic bz, er, input logic [7:0] c);
        return {rd, cfg, en, bz, er, c};
    endfunction

    function automatic logic [15:0] outs();
        return {read_en, config_en, eng_en, busy, error, inst_count};
    endfunction

    task automatic add(input logic ci, cd, fe, input logic [3:0] m, input logic l,
                       input logic [3:0] d, input logic clr, input logic [15:0] e);
        vec_t v;
        v.ci = ci; v.cd = cd; v.fe = fe; v.m = m; v.l = l; v.d = d; v.clr = clr; v.e = e;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        config_in = 0; config_done = 0; fifo_empty = 1; inst_mask = '0;
        inst_last = 0; eng_done = '0; clear_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 0;
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(ev(0,0,4'b0000,0,0,0)));
        n_rst = 1;
        @(negedge clk);
    endtask

    task automatic go_fetch();
        config_in = 1; @(negedge clk);
        config_in = 0; config_done = 1; @(negedge clk);
        config_done = 0; @(negedge clk);
    endtask

    task automatic run_frame(input int n);
        logic [3:0] m, d, cur_en, prev_en;
        int expect_at, min_rd, remaining, dly, age, idx, cyc;
        bit inflight, ended;
        fq_m.delete(); fq_l.delete(); exp_eng.delete();
        for (int i = 0; i < n; i++) begin
            m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) m = '0;
            fq_m.push_back(m);
            fq_l.push_back(i == n - 1);
        end
        go_fetch();
        prev_en = '0; inflight = 0; ended = 0; expect_at = -1; min_rd = 0;
        remaining = 0; dly = 0; age = 0; cyc = 0;
        while (cyc < 600 && !ended) begin
            cur_en = eng_en;
            if (cur_en != '0 && cur_en != prev_en) begin
                if (exp_eng.size() == 0) chk("eng_unexpected", 32'(cur_en), 0);
                else begin
                    idx = exp_eng.pop_front();
                    chk("eng_seq", 32'(cur_en), 32'(1) << idx);
                end
                chk("en_latency", cyc, expect_at);
                age = 0;
                dly = $urandom_range(0, TO - 1);
            end
            d = 4'($urandom_range(0, 15)) & ~cur_en;
            if (cur_en != '0 && age == dly) d = d | cur_en;
            fifo_empty  = (fq_m.size() == 0) || ($urandom_range(0, 3) == 0);
            inst_mask   = (fq_m.size() != 0) ? fq_m[0] : 4'($urandom_range(0, 15));
            inst_last   = (fq_l.size() != 0) ? fq_l[0] : 1'($urandom_range(0, 1));
            eng_done    = d;
            config_done = 1'($urandom_range(0, 1));
            clear_err   = 1'($urandom_range(0, 1));
            #1;
            if (read_en) begin
                chk("rd_nonempty", 32'(fifo_empty), 0);
                chk("rd_engine_idle", 32'(inflight), 0);
                chk("rd_min_gap", 32'(cyc >= min_rd), 1);
                chk("cnt_at_pop", 32'(inst_count), mc);
                if (fq_m.size() != 0) begin
                    m = fq_m.pop_front();
                    void'(fq_l.pop_front());
                    if (m == '0) mc = (mc + 1) % 256;
                    else begin
                        remaining = 0;
                        for (int b = 0; b < NE; b++)
                            if (m[b]) begin exp_eng.push_back(b); remaining++; end
                        inflight  = 1;
                        expect_at = cyc + 1;
                    end
                end
            end
            if ((d & cur_en) != '0) begin
                remaining--;
                if (remaining == 0) begin
                    inflight = 0;
                    mc = (mc + 1) % 256;
                    min_rd = cyc + 2;
                end else expect_at = cyc + 2;
            end
            if (cur_en != '0) age++;
            prev_en = cur_en;
            if (!busy) ended = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("frame_end", 32'(ended), 1);
        chk("frame_no_error", 32'(error), 0);
        chk("frame_eng_left", exp_eng.size(), 0);
        chk("frame_fifo_left", fq_m.size(), 0);
        chk("frame_count", 32'(inst_count), mc);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        // inputs: ci cd fe mask last done clr ; expected outputs
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,0,4'b0000,0,0,0));
        add(1,0,1,4'b0000,0,4'b0000,0, ev(0,0,4'b0000,0,0,0));
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,1,4'b0000,1,0,0));
        add(0,0,1,4'b0000,0,4'b0000,1, ev(0,1,4'b0000,1,0,0));
        add(0,0,1,4'b0000,0,4'b0001,0, ev(0,1,4'b0000,1,0,0));
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,1,4'b0000,1,0,0));
        add(0,1,1,4'b0000,0,4'b0000,0, ev(0,1,4'b0000,1,0,0));
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,0,4'b0000,1,0,0));
        add(0,0,1,4'b0011,0,4'b0000,0, ev(0,0,4'b0000,1,0,0));
        add(0,0,0,4'b0011,0,4'b0000,0, ev(1,0,4'b0000,1,0,0));
        add(0,0,1,4'b0100,1,4'b0100,0, ev(0,0,4'b0001,1,0,0));
        add(1,1,1,4'b0100,1,4'b0000,1, ev(0,0,4'b0001,1,0,0));
        add(0,0,1,4'b0100,1,4'b0001,0, ev(0,0,4'b0001,1,0,0));
        add(0,0,0,4'b0100,1,4'b0000,0, ev(0,0,4'b0000,1,0,0));
        add(0,0,1,4'b0100,1,4'b0000,0, ev(0,0,4'b0010,1,0,0));
        add(0,1,1,4'b0100,1,4'b0001,0, ev(0,0,4'b0010,1,0,0));
        add(0,0,1,4'b0100,1,4'b0010,0, ev(0,0,4'b0010,1,0,0));
        add(0,0,0,4'b0100,1,4'b0000,0, ev(0,0,4'b0000,1,0,0));
        add(0,0,0,4'b0100,1,4'b0000,0, ev(1,0,4'b0000,1,0,1));
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,0,4'b0100,1,0,1));
        add(0,0,1,4'b0000,0,4'b1011,0, ev(0,0,4'b0100,1,0,1));
        add(0,0,1,4'b0000,0,4'b0100,0, ev(0,0,4'b0100,1,0,1));
        add(0,0,1,4'b0000,0,4'b0000,0, ev(0,0,4'b0000,1,0,1));
        add(0,0,0,4'b0001,0,4'b0000,0, ev(0,0,4'b0000,0,0,2));

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            config_in = vq[i].ci; config_done = vq[i].cd; fifo_empty = vq[i].fe;
            inst_mask = vq[i].m; inst_last = vq[i].l; eng_done = vq[i].d; clear_err = vq[i].clr;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].e));
            @(negedge clk);
        end

        // zero-mask instruction followed by a single-engine last instruction
        do_reset();
        go_fetch();
        fifo_empty = 0; inst_mask = 4'b0000; inst_last = 0; #1;
        chk("zm_pop", 32'({read_en, eng_en}), 32'(5'b1_0000));
        @(negedge clk);
        inst_mask = 4'b0001; inst_last = 1; #1;
        chk("zm_count", 32'(inst_count), 1);
        chk("zm_pop2", 32'(read_en), 1);
        @(negedge clk);
        fifo_empty = 1; eng_done = 4'b0001; #1;
        chk("zm_run", 32'(eng_en), 32'(4'b0001));
        @(negedge clk);
        eng_done = '0; #1;
        chk("zm_gap", 32'(outs()), 32'(ev(0,0,4'b0000,1,0,1)));
        @(negedge clk); #1;
        chk("zm_idle", 32'(outs()), 32'(ev(0,0,4'b0000,0,0,2)));
        @(negedge clk);

        // watchdog expiry on engine 1
        go_fetch();
        fifo_empty = 0; inst_mask = 4'b0010; inst_last = 1; #1;
        @(negedge clk);
        fifo_empty = 1;
        for (int k = 0; k < TO; k++) begin
            eng_done = (k == 3) ? 4'b0101 : 4'b0000; #1;
            chk($sformatf("to_run%0d", k), 32'({eng_en, error}), 32'(5'b0010_0));
            @(negedge clk);
        end
        eng_done = '0; #1;
        chk("to_error", 32'(outs()), 32'(ev(0,0,4'b0000,0,1,2)));
        @(negedge clk); #1;
        chk("to_sticky", 32'(error), 1);
        clear_err = 1;
        @(negedge clk);
        clear_err = 0; #1;
        chk("to_cleared", 32'(outs()), 32'(ev(0,0,4'b0000,0,0,2)));
        @(negedge clk);

        // done coincides with the watchdog limit; foreign done ignored earlier
        go_fetch();
        fifo_empty = 0; inst_mask = 4'b0001; inst_last = 1; #1;
        @(negedge clk);
        fifo_empty = 1;
        for (int k = 0; k < TO; k++) begin
            eng_done = (k == TO - 1) ? 4'b0001 : ((k == 2) ? 4'b0100 : 4'b0000); #1;
            chk($sformatf("lim_run%0d", k), 32'(eng_en), 32'(4'b0001));
            @(negedge clk);
        end
        eng_done = '0; #1;
        chk("lim_gap", 32'(outs()), 32'(ev(0,0,4'b0000,1,0,2)));
        @(negedge clk); #1;
        chk("lim_idle", 32'(outs()), 32'(ev(0,0,4'b0000,0,0,3)));
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        go_fetch();
        fifo_empty = 0; inst_mask = 4'b0100; inst_last = 0; #1;
        @(negedge clk);
        fifo_empty = 1; #1;
        chk("ar_run", 32'(eng_en), 32'(4'b0100));
        #2 n_rst = 0;
        #1 chk("ar_async", 32'(outs()), 0);
        @(negedge clk);
        fifo_empty = 0; inst_mask = 4'b0001; n_rst = 1; #1;
        chk("ar_idle", 32'(outs()), 0);
        @(negedge clk); #1;
        chk("ar_idle2", 32'(outs()), 0);
        @(negedge clk);

        // instruction counter wraps
        do_reset();
        go_fetch();
        fifo_empty = 0; inst_mask = '0; inst_last = 0;
        repeat (255) @(negedge clk);
        #1 chk("wrap_255", 32'(inst_count), 255);
        @(negedge clk); #1;
        chk("wrap_0", 32'(inst_count), 0);
        inst_last = 1;
        @(negedge clk); #1;
        chk("wrap_idle", 32'(outs()), 32'(ev(0,0,4'b0000,0,0,1)));
        @(negedge clk);

        // randomized frames against the queue model
        do_reset();
        mc = 0;
        for (int f = 0; f < 8; f++) run_frame($urandom_range(1, 6));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
